// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU MEM stage has priority,
// a starvation counter force-grants the host, and a lock handshake gives the host exclusive use.
module dmem_arbiter #(
    parameter int AW            = 8,
    parameter int DW            = 64,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    input  logic          host_lock,
    output logic          host_lock_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_wait;
    logic [3:0] w_wait_next;
    logic       r_cpu_rvalid;
    logic       r_host_rvalid;
    logic       w_cpu_gnt;
    logic       w_host_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait        <= 4'd0;
            r_cpu_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wait        <= w_wait_next;
            r_cpu_rvalid  <= w_cpu_gnt & ~cpu_we;
            r_host_rvalid <= w_host_gnt & ~host_we;
        end
    end

    // A request is accepted in the cycle its grant is high (CPU: cpu_stall low);
    // otherwise the requester must hold its request and operands unchanged.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_host_gnt = 1'b0;
        if (!reset) begin
            unique case (r_state)
                ST_RUN: begin
                    if (cpu_req) begin
                        if ((r_wait == MAX_WAIT) && host_req) w_host_gnt = 1'b1;
                        else                                  w_cpu_gnt  = 1'b1;
                    end else begin
                        w_host_gnt = host_req;
                    end
                end
                ST_LOCKED: w_host_gnt = host_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_RUN:    w_state_next = host_lock ? ST_DRAIN  : ST_RUN;
            ST_DRAIN:  w_state_next = host_lock ? ST_LOCKED : ST_RUN;
            ST_LOCKED: w_state_next = host_lock ? ST_LOCKED : ST_RUN;
            default:   w_state_next = ST_RUN;
        endcase
    end

    // The counter only measures starvation under arbitration; DRAIN freezes it.
    always_comb begin
        w_wait_next = r_wait;
        if (r_state == ST_RUN) begin
            if (host_req && !w_host_gnt)
                w_wait_next = (r_wait == MAX_WAIT) ? r_wait : r_wait + 4'd1;
            else
                w_wait_next = 4'd0;
        end else if (w_state_next == ST_LOCKED) begin
            w_wait_next = 4'd0;
        end
    end

    always_comb begin
        mem_en    = w_cpu_gnt | w_host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    assign cpu_stall     = ~reset & cpu_req & ~w_cpu_gnt;
    assign host_gnt      = w_host_gnt;
    assign cpu_rdata     = mem_rdata;
    assign host_rdata    = mem_rdata;
    assign cpu_rvalid    = r_cpu_rvalid & ~reset;
    assign host_rvalid   = r_host_rvalid & ~reset;
    assign host_lock_ack = (r_state == ST_LOCKED) & ~reset;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked each cycle
// against a priority/starvation/lock reference model and a shadow memory.
module tb_dmem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 64;
    localparam int MAXW = 4;

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_LOCKED = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          host_lock;
    logic          host_lock_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    o_dbg_state;

    // clock / reset
    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .HOST_MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .host_lock(host_lock), .host_lock_ack(host_lock_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .o_dbg_state(o_dbg_state)
    );

    // memory device attached to the arbiter
    logic [DW-1:0] dev_mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= dev_mem[mem_addr];
        end
    end

    // reference model and scoreboard
    int            m_mode;
    int            m_denied;
    bit            m_cpu_pend, m_host_pend;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] host_exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already set; check at negedge, advance model, return at posedge+1.
    task automatic cycle();
        bit            host_win, cpu_win;
        int            nm;
        logic [DW-1:0] e;
        @(negedge clk);
        host_win = 1'b0;
        cpu_win  = 1'b0;
        if (reset) begin
            chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
            chk("rst_host_gnt", 64'(host_gnt), 64'd0);
            chk("rst_mem_en", 64'(mem_en), 64'd0);
            chk("rst_mem_we", 64'(mem_we), 64'd0);
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
            chk("rst_mem_wdata", mem_wdata, 64'd0);
            chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
            chk("rst_host_rvalid", 64'(host_rvalid), 64'd0);
            chk("rst_lock_ack", 64'(host_lock_ack), 64'd0);
            m_mode      = M_RUN;
            m_denied    = 0;
            m_cpu_pend  = 1'b0;
            m_host_pend = 1'b0;
            cpu_exp_q.delete();
            host_exp_q.delete();
        end else begin
            if (m_mode == M_RUN) begin
                host_win = host_req && (!cpu_req || m_denied >= MAXW);
                cpu_win  = cpu_req && !host_win;
            end else if (m_mode == M_LOCKED) begin
                host_win = host_req;
            end
            chk("state", 64'(o_dbg_state), 64'(m_mode));
            chk("lock_ack", 64'(host_lock_ack), 64'(m_mode == M_LOCKED));
            chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !cpu_win));
            chk("host_gnt", 64'(host_gnt), 64'(host_win));
            chk("mem_en", 64'(mem_en), 64'(cpu_win || host_win));
            chk("mem_we", 64'(mem_we), 64'(cpu_win ? cpu_we : (host_win ? host_we : 1'b0)));
            chk("mem_addr", 64'(mem_addr), 64'(cpu_win ? cpu_addr : (host_win ? host_addr : 8'd0)));
            chk("mem_wdata", mem_wdata, cpu_win ? cpu_wdata : (host_win ? host_wdata : 64'd0));
            chk("cpu_rvalid", 64'(cpu_rvalid), 64'(m_cpu_pend));
            chk("host_rvalid", 64'(host_rvalid), 64'(m_host_pend));
            if (m_cpu_pend && cpu_exp_q.size() > 0) begin
                e = cpu_exp_q.pop_front();
                chk("cpu_rdata", cpu_rdata, e);
            end
            if (m_host_pend && host_exp_q.size() > 0) begin
                e = host_exp_q.pop_front();
                chk("host_rdata", host_rdata, e);
            end
            m_cpu_pend  = cpu_win && !cpu_we;
            m_host_pend = host_win && !host_we;
            if (m_cpu_pend)  cpu_exp_q.push_back(ref_mem[cpu_addr]);
            if (m_host_pend) host_exp_q.push_back(ref_mem[host_addr]);
            if (cpu_win && cpu_we)   ref_mem[cpu_addr]  = cpu_wdata;
            if (host_win && host_we) ref_mem[host_addr] = host_wdata;
            if (m_mode == M_RUN)
                m_denied = (host_req && !host_win) ? ((m_denied < MAXW) ? m_denied + 1 : MAXW) : 0;
            case (m_mode)
                M_RUN:   nm = host_lock ? M_DRAIN : M_RUN;
                M_DRAIN: nm = host_lock ? M_LOCKED : M_RUN;
                default: nm = host_lock ? M_LOCKED : M_RUN;
            endcase
            if (nm == M_LOCKED && m_mode != M_LOCKED) m_denied = 0;
            m_mode = nm;
        end
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_host(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = req; host_we = we; host_addr = a; host_wdata = d;
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < 256; i++) begin
            v = {$urandom, $urandom};
            dev_mem[i] = v;
            ref_mem[i] = v;
        end
        dev_mem[5] = 64'h1122334455667788;
        ref_mem[5] = 64'h1122334455667788;
        m_mode = M_RUN; m_denied = 0; m_cpu_pend = 1'b0; m_host_pend = 1'b0;
        host_lock = 1'b0;
        reset = 1'b1;
        // requests asserted during reset must stay masked
        set_cpu(1'b1, 1'b0, 8'h03, 64'd0);
        set_host(1'b1, 1'b1, 8'h04, 64'h55);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset = 1'b0;

        // CPU load from address 5
        set_host(1'b0, 1'b0, 8'h00, 64'd0);
        set_cpu(1'b1, 1'b0, 8'h05, 64'd0);
        cycle();
        chk("cpu_load5_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("cpu_load5_rdata", cpu_rdata, 64'h1122334455667788);
        set_cpu(1'b0, 1'b0, 8'h00, 64'd0);
        cycle();

        // host write then read back
        set_host(1'b1, 1'b1, 8'h10, 64'hDEADBEEF);
        cycle();
        set_host(1'b1, 1'b0, 8'h10, 64'd0);
        cycle();
        chk("host_rb_rvalid", 64'(host_rvalid), 64'd1);
        chk("host_rb_rdata", host_rdata, 64'hDEADBEEF);
        chk("host_rb_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        set_host(1'b0, 1'b0, 8'h00, 64'd0);
        cycle();

        // both requesting continuously: starvation forces every 5th grant to host
        set_cpu(1'b1, 1'b0, 8'h21, 64'd0);
        set_host(1'b1, 1'b0, 8'h22, 64'd0);
        repeat (15) cycle();
        set_cpu(1'b0, 1'b0, 8'h00, 64'd0);
        set_host(1'b0, 1'b0, 8'h00, 64'd0);
        cycle();

        // lock raised together with a CPU load, host traffic while locked, then release
        set_cpu(1'b1, 1'b0, 8'h07, 64'd0);
        host_lock = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            set_host(1'b1, 1'(i % 2), 8'(8'h30 + i), {$urandom, $urandom});
            cycle();
        end
        set_host(1'b0, 1'b0, 8'h00, 64'd0);
        host_lock = 1'b0;
        cycle();
        cycle();
        set_cpu(1'b0, 1'b0, 8'h00, 64'd0);
        cycle();

        // one-cycle lock pulse
        host_lock = 1'b1;
        cycle();
        host_lock = 1'b0;
        repeat (3) cycle();

        // reset while locked with a host read outstanding
        host_lock = 1'b1;
        repeat (3) cycle();
        set_host(1'b1, 1'b0, 8'h31, 64'd0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        host_lock = 1'b0;
        set_host(1'b0, 1'b0, 8'h00, 64'd0);
        cycle();

        // random traffic
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) host_lock = ~host_lock;
            set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 15)), {$urandom, $urandom});
            set_host(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 15)), {$urandom, $urandom});
            cycle();
        end
        reset = 1'b0;
        host_lock = 1'b0;
        set_cpu(1'b0, 1'b0, 8'h00, 64'd0);
        set_host(1'b0, 1'b0, 8'h00, 64'd0);
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
